// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, one bit per clock, LSB first, through a
// single full-subtractor cell and a borrow flip-flop, with start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] r_sr_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             d_bit;
    logic             borrow_d;
    logic [WIDTH-1:0] r_sr_d;

    // Full-subtractor cell on the current LSBs and the running borrow
    assign d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign borrow_d = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    assign r_sr_d   = {d_bit, r_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= A;
                        b_sr_q   <= B;
                        r_sr_q   <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    r_sr_q   <= r_sr_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    // Last bit: publish the result including this edge's bit and borrow
                    if (cnt_q == LAST) begin
                        diff_q  <= r_sr_d;
                        bout_q  <= borrow_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign DIFF = diff_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases at WIDTH=4 and a
// randomized sweep at WIDTH=8 against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] A4 = '0, B4 = '0;
    logic       busy4, done4, BOUT4;
    logic [3:0] DIFF4;

    logic       start8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0;
    logic       busy8, done8, BOUT8;
    logic [7:0] DIFF8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .A(A4), .B(B4),
        .busy(busy4), .done(done4), .DIFF(DIFF4), .BOUT(BOUT4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .A(A8), .B(B8),
        .busy(busy8), .done(done8), .DIFF(DIFF8), .BOUT(BOUT8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic busy_s(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic done_s(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic bout_s(input int w);
        return (w == 4) ? BOUT4 : BOUT8;
    endfunction
    function automatic logic [31:0] diff_s(input int w);
        return (w == 4) ? {28'd0, DIFF4} : {24'd0, DIFF8};
    endfunction

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        if (w == 4) begin A4 = a[3:0]; B4 = b[3:0]; start4 = s; end
        else begin A8 = a[7:0]; B8 = b[7:0]; start8 = s; end
    endtask

    // One full operation; the expected result comes from plain modular arithmetic.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] mask;
        logic [31:0] exp_diff;
        logic        exp_bout;
        logic [31:0] prev;
        int          busy_cnt;
        int          unstable;
        bit          seen;
        mask     = (w == 4) ? 32'hF : 32'hFF;
        exp_diff = (a - b) & mask;
        exp_bout = ((a & mask) < (b & mask));
        busy_cnt = 0;
        unstable = 0;
        seen     = 0;
        @(negedge clk);
        drive(w, a, b, 1'b1);
        prev = diff_s(w);
        @(negedge clk);
        drive(w, $urandom, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (done_s(w)) begin seen = 1; break; end
            if (busy_s(w)) busy_cnt++;
            if (diff_s(w) !== prev) unstable++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, w);
        check({tag, "_diff_hold"}, unstable, 0);
        check({tag, "_diff"}, diff_s(w), exp_diff);
        check({tag, "_bout"}, {31'd0, bout_s(w)}, {31'd0, exp_bout});
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'd0, done_s(w)}, 32'd0);
    endtask

    initial begin
        int last, pulses, bad, dpulse, drained;
        logic [31:0] prev, ra, rb;

        // Reset state
        #1;
        check("rst_busy", {31'd0, busy4}, 0);
        check("rst_done", {31'd0, done4}, 0);
        check("rst_diff", {28'd0, DIFF4}, 0);
        check("rst_bout", {31'd0, BOUT4}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic and borrow cases
        op(4, 9, 3, "t1");
        op(4, 3, 9, "t2a");
        op(4, 0, 1, "t2b");
        op(4, 5, 5, "t2c");

        // Start during RUN is ignored
        @(negedge clk); A4 = 12; B4 = 4; start4 = 1;
        @(negedge clk); start4 = 0;
        @(negedge clk);
        @(negedge clk); A4 = 1; B4 = 2; start4 = 1;
        @(negedge clk); start4 = 0;
        @(negedge clk);
        check("t3_done", {31'd0, done4}, 1);
        check("t3_diff", {28'd0, DIFF4}, 8);
        check("t3_bout", {31'd0, BOUT4}, 0);
        dpulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) dpulse++;
        end
        check("t3_extra_done", dpulse, 0);

        // Reset mid-run clears everything and discards the operation
        @(negedge clk); A4 = 7; B4 = 2; start4 = 1;
        @(negedge clk); start4 = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t4_busy", {31'd0, busy4}, 0);
        check("t4_done", {31'd0, done4}, 0);
        check("t4_diff", {28'd0, DIFF4}, 0);
        check("t4_bout", {31'd0, BOUT4}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dpulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4 || busy4) dpulse++;
        end
        check("t4_no_done", dpulse, 0);
        op(4, 7, 2, "t4_fresh");

        // Start held high: one result every WIDTH+1 cycles
        @(negedge clk); A4 = 10; B4 = 3; start4 = 1;
        last = -1; pulses = 0; bad = 0; prev = {28'd0, DIFF4};
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (done4) begin
                if (pulses > 0) check("t5_period", c - last, 5);
                check("t5_diff", {28'd0, DIFF4}, 7);
                last = c;
                pulses++;
            end else if ({28'd0, DIFF4} !== prev) begin
                bad++;
            end
            prev = {28'd0, DIFF4};
        end
        check("t5_pulses", pulses, 3);
        check("t5_stable", bad, 0);
        start4 = 0;
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy4 && !done4) begin drained = 1; break; end
        end
        check("t5_drain", drained, 1);

        // WIDTH=8 extremes and randomized sweep
        op(8, 255, 0, "t6a");
        op(8, 0, 255, "t6b");
        for (int k = 0; k < 24; k++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            op(8, ra, rb, "t6r");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing DIFF = A - B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It trades the area of a WIDTH-bit ripple datapath for WIDTH cycles of latency. It is the inverse-operation counterpart of the lab's ripple adders. A start/busy/done handshake lets a top-level FSM or button/switch interface on the Nexys A7 drive it.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE
A  input  WIDTH  minuend; captured on the accepting edge
B  input  WIDTH  subtrahend; captured on the accepting edge
busy  output  1  high while a subtraction is in progress (RUN state)
done  output  1  one-cycle pulse: DIFF/BOUT just updated
DIFF  output  WIDTH  result A - B modulo 2^WIDTH; registered
BOUT  output  1  final borrow: 1 when A < B as unsigned values

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, DIFF=0, BOUT=0; internal shift registers, borrow flip-flop and bit counter cleared. Reset is honoured at any time, including mid-RUN. The operation in flight is discarded, and no done pulse is issued for it.
- States: IDLE, RUN, DONE.
- IDLE and DONE, start=1 at edge E0:
  - load a_sr<=A and b_sr<=B; borrow<=0; cnt<=0; state<=RUN.
  - busy goes high after E0, and done goes low after E0.
- IDLE and DONE, start=0: DONE->IDLE; IDLE holds.
- RUN, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow)
  - a_sr and b_sr shift right by 1.
  - d shifts into the MSB of the internal result register r_sr (shift right).
  - cnt <= cnt + 1.
- RUN exit: on the edge where cnt == WIDTH-1 (the WIDTH-th bit edge):
  - DIFF <= final r_sr value, including the bit computed this edge.
  - BOUT <= borrow-out computed this edge.
  - done <= 1; busy <= 0; state <= DONE.
- Latency: start accepted at E0; done high in the cycle after edge E0+WIDTH. For WIDTH=4, done is visible after the 4th edge following acceptance.
- done is high for exactly one cycle (the DONE state).
- DIFF and BOUT change only on the RUN->DONE edge and on reset. They hold stable during RUN and while idle, until the next completion.
- start while busy (RUN) is ignored. Operands are not re-sampled, and the operation continues unchanged.
- Back-to-back operation: start held high in DONE is accepted, giving throughput of one result per WIDTH+1 cycles.
- A and B may change freely after the accepting edge.
- Counter width is $clog2(WIDTH)+1. cnt does not wrap during a legal operation.
- Arithmetic: results are unsigned modulo 2^WIDTH, equivalent to the two's-complement difference. BOUT is the unsigned borrow; no signed-overflow flag is provided.

Test Plan:
1. WIDTH=4, reset then A=9, B=3, start pulse -> busy=1 for 4 cycles; done pulse once; DIFF=6, BOUT=0.
2. WIDTH=4, A=3, B=9 -> DIFF=4'hA, BOUT=1. Then A=0, B=1 -> DIFF=4'hF, BOUT=1. Then A=5, B=5 -> DIFF=0, BOUT=0.
3. Start A=12, B=4; two cycles later pulse start with A=1, B=2 -> second start ignored; result DIFF=8, BOUT=0; exactly one done pulse.
4. Start A=7, B=2; assert reset_n low mid-RUN (after 2 edges) -> immediately busy=0, done=0, DIFF=0, BOUT=0; no done pulse afterwards. A fresh start with A=7, B=2 gives DIFF=5.
5. Hold start high continuously with A=10, B=3 -> done pulses every 5 cycles, DIFF=7 each time. Verify DIFF is stable between pulses.
6. WIDTH=8: A=255, B=0 -> DIFF=255, BOUT=0. A=0, B=255 -> DIFF=1, BOUT=1. Then randomized sweep against the reference model (A-B) mod 256, with BOUT=(A<B).
